urf_access_ctrl: RTL and testbench
==================================

# urf_access_ctrl

Access controller for the universal register array: arbitrates single-cycle read/write requests from NUM_REQ independent requesters onto the array's one write port and one read port, returning read data to the winning requester. Also provides a hardware clear sequencer that zeroes every array entry without a reset. Sits between the requester fabric and one universal register array instance, and is the only driver of the array's control inputs.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATA_WIDTH, 8: array word width
- ADDR_WIDTH, 4: array address width; array depth = 2**ADDR_WIDTH
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request; held stable until accepted
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- req_ready  out  NUM_REQ  one-hot grant; accept = req_valid[i] & req_ready[i]
- rsp_valid  out  NUM_REQ  one-hot read-response strobe
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters
- clr_start  in  1  pulse: start clear sweep
- clr_done  out  1  one-cycle pulse at end of sweep
- ctrl_busy  out  1  high while clear sweep active
- arr_write_en, arr_read_en  out  1  array controls
- arr_write_addr, arr_read_addr  out  ADDR_WIDTH  array addresses
- arr_write_data  out  DATA_WIDTH  array write data
- arr_read_data  in  DATA_WIDTH  array registered read data

## Operation
- FSM states: IDLE (serve requests) and CLEAR (sweep). Reset -> IDLE.
- IDLE: round-robin arbiter picks one valid requester per cycle; req_ready is high only for the winner, 0 for all others.
- Round-robin: search starts at last_grant+1 (mod NUM_REQ); last_grant updates only on accept; reset value NUM_REQ-1, so requester 0 has top priority after reset.
- Accepted write: arr_write_en=1, arr_write_addr/data from winner; arr_read_en=0.
- Accepted read: arr_read_en=1, arr_read_addr from winner; arr_write_en=0; winner index registered as pending response.
- Never assert arr_write_en and arr_read_en in the same cycle.
- clr_start in IDLE: enter CLEAR next cycle; clr_start wins over requests in that cycle (req_ready all 0).
- CLEAR: a sweep counter starting at 0 drives arr_write_addr; arr_write_data=0; arr_write_en=1 every cycle for 2**ADDR_WIDTH cycles; req_ready all 0; ctrl_busy=1. After address 2**ADDR_WIDTH-1, return to IDLE with a clr_done pulse in the first IDLE cycle.
- clr_start during CLEAR: ignored; no restart.
- Reset mid-sweep: abort immediately; the array is left partially cleared and no clr_done is issued.
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata passthrough of arr_read_data (array resets to 0), clr_done 0, ctrl_busy 0, all arr_* controls 0, sweep counter 0, pending response cleared.

## Timing
- Grant is combinational from req_valid and registered state; an accept occurs in the same cycle a request is granted.
- Array controls are combinational from the grant; the array samples them at the end of accept cycle T.
- Read latency: rsp_valid[i]=1 in cycle T+1 only, with rsp_rdata = arr_read_data.
- Throughput: one accept per cycle; back-to-back reads give back-to-back responses.
- A write at T followed by a read of the same address at T+1 returns the new data at T+2.
- CLEAR occupies exactly 2**ADDR_WIDTH cycles of ctrl_busy; clr_done follows in the next cycle.

## Structure
- Shared package urf_pkg: FSM state enum (URF_IDLE, URF_CLEAR), and default constants for NUM_REQ, DATA_WIDTH, and ADDR_WIDTH.
- One sub-module, urf_rr_arbiter: parameter NUM_REQ; inputs clk, rst, req vector, and an advance signal; output one-hot grant; contains the last_grant register. All other logic stays in urf_access_ctrl.

## Test plan
- Reset, then requester 2 writes 0xA5 to address 3, then reads address 3 -> req_ready[2] high in each request cycle; rsp_valid[2] one cycle after the read accept with rsp_rdata=0xA5.
- All four requesters issue continuous reads from reset -> grants 0,1,2,3,0 on consecutive cycles; each rsp_valid follows its grant by one cycle.
- Requester 1 writes 0x3C to address 7 at T; requester 0 reads address 7 at T+1 -> rsp_rdata=0x3C at T+2.
- Fill all 16 entries with nonzero data, pulse clr_start while requests are pending -> no grant that cycle; ctrl_busy high for 16 cycles with arr_write_addr 0..15; clr_done pulses once; subsequent reads return 0x00.
- Pulse clr_start again at sweep cycle 5 -> sweep length still 16 cycles, exactly one clr_done.
- Assert rst at sweep cycle 8 -> all outputs return to reset values at once; no clr_done; entries 0..7 read 0x00; the array's own reset zeroes the remaining entries.

Source files
------------

// File: rtl/urf_pkg.sv
// rtl/urf_pkg.sv - shared types and default sizes for the register-array access controller
package urf_pkg;

    typedef enum logic [0:0] {
        URF_IDLE  = 1'b0,
        URF_CLEAR = 1'b1
    } urf_state_e;

    localparam int URF_NUM_REQ    = 4;
    localparam int URF_DATA_WIDTH = 8;
    localparam int URF_ADDR_WIDTH = 4;

endpackage

// File: rtl/urf_rr_arbiter.sv
// rtl/urf_rr_arbiter.sv - round-robin one-hot arbiter; search begins after the last accepted winner
module urf_rr_arbiter
    import urf_pkg::*;
#(
    parameter int NUM_REQ = URF_NUM_REQ
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] last_grant_q;
    logic [IDX_W-1:0] last_grant_d;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        win   = last_grant_q;
        idx   = '0;
        found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = IDX_W'((int'(last_grant_q) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                win        = idx;
                found      = 1'b1;
            end
        end
        last_grant_d = advance ? win : last_grant_q;
    end

    // Resetting to the top index makes requester 0 the first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/urf_access_ctrl.sv
// rtl/urf_access_ctrl.sv - arbitrates requester reads/writes onto the register array and runs the clear sweep
module urf_access_ctrl
    import urf_pkg::*;
#(
    parameter int NUM_REQ    = URF_NUM_REQ,
    parameter int DATA_WIDTH = URF_DATA_WIDTH,
    parameter int ADDR_WIDTH = URF_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    input  logic                          clr_start,
    output logic                          clr_done,
    output logic                          ctrl_busy,
    output logic                          arr_write_en,
    output logic                          arr_read_en,
    output logic [ADDR_WIDTH-1:0]         arr_write_addr,
    output logic [ADDR_WIDTH-1:0]         arr_read_addr,
    output logic [DATA_WIDTH-1:0]         arr_write_data,
    input  logic [DATA_WIDTH-1:0]         arr_read_data
);

    urf_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  sweep_q, sweep_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic                   clr_done_q, clr_done_d;

    logic                   arb_en;
    logic [NUM_REQ-1:0]     grant;
    logic                   accept;
    logic                   sel_write;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_data;

    // Requests are hidden from the arbiter while sweeping, when a sweep is
    // being launched, and during reset so no grant leaks out.
    assign arb_en = (state_q == URF_IDLE) && !clr_start && !rst;

    urf_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid & {NUM_REQ{arb_en}}),
        .advance (accept),
        .grant   (grant)
    );

    assign accept = |grant;

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        sweep_d        = sweep_q;
        rsp_valid_d    = '0;
        clr_done_d     = 1'b0;
        ctrl_busy      = 1'b0;
        arr_write_en   = 1'b0;
        arr_read_en    = 1'b0;
        arr_write_addr = '0;
        arr_read_addr  = '0;
        arr_write_data = '0;
        case (state_q)
            URF_IDLE: begin
                if (clr_start) begin
                    state_d = URF_CLEAR;
                    sweep_d = '0;
                end else if (accept) begin
                    if (sel_write) begin
                        arr_write_en   = 1'b1;
                        arr_write_addr = sel_addr;
                        arr_write_data = sel_data;
                    end else begin
                        arr_read_en    = 1'b1;
                        arr_read_addr  = sel_addr;
                        rsp_valid_d    = grant;
                    end
                end
            end
            URF_CLEAR: begin
                ctrl_busy      = 1'b1;
                arr_write_en   = 1'b1;
                arr_write_addr = sweep_q;
                sweep_d        = sweep_q + ADDR_WIDTH'(1);
                if (sweep_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d    = URF_IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = URF_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= URF_IDLE;
            sweep_q     <= '0;
            rsp_valid_q <= '0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            rsp_valid_q <= rsp_valid_d;
            clr_done_q  <= clr_done_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = arr_read_data;
    assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_urf_access_ctrl.sv
// tb/tb_urf_access_ctrl.sv - scoreboard bench for urf_access_ctrl with a behavioural register array
module tb_urf_access_ctrl;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_write = '0;
    logic [NR*AW-1:0]  req_addr  = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              clr_start = 1'b0;
    logic              clr_done;
    logic              ctrl_busy;
    logic              arr_write_en, arr_read_en;
    logic [AW-1:0]     arr_write_addr, arr_read_addr;
    logic [DW-1:0]     arr_write_data;
    logic [DW-1:0]     arr_read_data;

    logic [DW-1:0]     mem [2**AW];

    typedef struct {
        int          idx;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    urf_access_ctrl #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .clr_start      (clr_start),
        .clr_done       (clr_done),
        .ctrl_busy      (ctrl_busy),
        .arr_write_en   (arr_write_en),
        .arr_read_en    (arr_read_en),
        .arr_write_addr (arr_write_addr),
        .arr_read_addr  (arr_read_addr),
        .arr_write_data (arr_write_data),
        .arr_read_data  (arr_read_data)
    );

    // Behavioural array: registered read, resets to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
            arr_read_data <= '0;
        end else begin
            if (arr_write_en) mem[arr_write_addr] <= arr_write_data;
            if (arr_read_en) arr_read_data <= mem[arr_read_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic req_one(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        req_valid = '0;
        req_valid[r] = 1'b1;
        req_write[r] = wr;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*DW +: DW] = d;
        @(negedge clk);
        check("req_ready_single", 32'(req_ready), 32'(1 << r));
        if (!wr) begin
            e.idx = r;
            e.data = d;
            exp_q.push_back(e);
        end
        next_cycle();
        req_valid = '0;
    endtask

    task automatic fill();
        for (int a = 0; a < 2**AW; a++) req_one(a % NR, 1'b1, AW'(a), DW'(8'h50 + a));
    endtask

    // Drives one sweep; optionally re-pulses clr_start at sweep cycle 5 or
    // asserts reset at sweep cycle abort_at (-1 = run to completion).
    task automatic sweep(input bit retrig, input int abort_at);
        exp_t e;
        req_valid = '0;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0 +: AW] = 4'd5;
        clr_start = 1'b1;
        @(negedge clk);
        check("no_grant_on_clr_start", 32'(req_ready), 32'h0);
        next_cycle();
        for (int c = 0; c < 2**AW; c++) begin
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_busy", 32'(ctrl_busy), 32'h0);
                check("rst_wen", 32'(arr_write_en), 32'h0);
                check("rst_ready", 32'(req_ready), 32'h0);
                check("rst_done", 32'(clr_done), 32'h0);
                check("rst_rsp", 32'(rsp_valid), 32'h0);
                req_valid = '0;
                clr_start = 1'b0;
                next_cycle();
                rst = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    check("no_done_after_abort", 32'(clr_done), 32'h0);
                end
                next_cycle();
                return;
            end
            clr_start = retrig && (c == 5);
            @(negedge clk);
            check("sweep_busy", 32'(ctrl_busy), 32'h1);
            check("sweep_addr", 32'(arr_write_addr), 32'(c));
            check("sweep_wen_data", {23'h0, arr_write_en, arr_write_data}, 32'h100);
            check("sweep_no_grant", 32'(req_ready), 32'h0);
            next_cycle();
        end
        clr_start = 1'b0;
        @(negedge clk);
        check("busy_low_after_sweep", 32'(ctrl_busy), 32'h0);
        check("clr_done_pulse", 32'(clr_done), 32'h1);
        check("pending_grant_after_sweep", 32'(req_ready), 32'h1);
        e.idx = 0;
        e.data = 8'h00;
        exp_q.push_back(e);
        next_cycle();
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("clr_done_single", 32'(clr_done), 32'h0);
            next_cycle();
        end
    endtask

    // Response monitor: every strobe must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: rsp_valid=0x%0h with empty scoreboard at %0t", rsp_valid, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(1 << e.idx));
                    check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        #12;
        check("reset_ready", 32'(req_ready), 32'h0);
        check("reset_rsp", 32'(rsp_valid), 32'h0);
        check("reset_busy_done", {30'h0, ctrl_busy, clr_done}, 32'h0);
        check("reset_arr", {29'h0, arr_write_en, arr_read_en, 1'b0}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Four requesters reading continuously: strict rotation from 0.
        req_valid = 4'hF;
        req_write = 4'h0;
        req_addr  = {4'd9, 4'd6, 4'd4, 4'd1};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(1 << (k % NR)));
            check("rr_read_en", {30'h0, arr_read_en, arr_write_en}, 32'h2);
            e.idx = k % NR;
            e.data = 8'h00;
            exp_q.push_back(e);
            next_cycle();
        end
        req_valid = '0;
        next_cycle();

        // Requester 2 writes then reads back.
        req_one(2, 1'b1, 4'd3, 8'hA5);
        req_one(2, 1'b0, 4'd3, 8'hA5);
        next_cycle();

        // Write then immediate read of same address by another requester.
        req_one(1, 1'b1, 4'd7, 8'h3C);
        req_one(0, 1'b0, 4'd7, 8'h3C);
        next_cycle();

        fill();
        req_one(3, 1'b0, 4'd12, 8'h5C);
        next_cycle();
        sweep(1'b0, -1);
        req_one(0, 1'b0, 4'd0, 8'h00);
        req_one(1, 1'b0, 4'd7, 8'h00);
        req_one(2, 1'b0, 4'd15, 8'h00);

        fill();
        sweep(1'b1, -1);
        req_one(3, 1'b0, 4'd9, 8'h00);

        fill();
        sweep(1'b0, 8);
        for (int a = 0; a < 2**AW; a++) req_one(a % NR, 1'b0, AW'(a), 8'h00);

        repeat (3) next_cycle();
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
